fft_out_pingpong_ctrl: RTL
==========================

// Module: fft_out_pingpong_ctrl
// PURPOSE
// Sequences the two-bank (ping-pong) 512-point output buffer after CBFP stage 2.
// Write side: counts CBFP2 pop rows into the current bank; retires the bank when full.
// Read side: streams full banks to the downstream output interface in natural row order.
// Ends each bank's read by freeing it. Generates upstream backpressure and an overflow flag.
// PARAMETERS
// N_POINT     512  samples per frame (one bank)
// WR_SAMPLES  32   samples written per cbfp2_pop; WR_ROWS = N_POINT/WR_SAMPLES (16)
// RD_SAMPLES  16   samples read per rd_en; RD_ROWS = N_POINT/RD_SAMPLES (32)
// RD_LAT      1    buffer read latency in cycles, from rd_en to data valid (>=1)
// PORTS
// clk        in   1                     clock, rising edge
// rstn       in   1                     asynchronous active-low reset
// cbfp2_pop  in   1                     one WR_SAMPLES row presented by CBFP2 this cycle
// wr_en      out  1                     buffer write strobe (combinational: cbfp2_pop & ~wr_stall)
// wr_bank    out  1                     bank being written
// wr_addr    out  $clog2(WR_ROWS)       row address within wr_bank
// wr_stall   out  1                     both banks full; upstream must hold pops
// full_512   out  1                     1-cycle pulse: a bank has just been filled
// ovf_err    out  1                     sticky: pop arrived while wr_stall=1 (row dropped)
// out_ready  in   1                     downstream permits issue of next read row
// rd_en      out  1                     buffer read strobe
// rd_bank    out  1                     bank being read
// rd_addr    out  $clog2(RD_ROWS)       row address within rd_bank
// out_valid  out  1                     read data valid (rd_en delayed RD_LAT)
// out_sof    out  1                     with out_valid: first row of frame
// out_eof    out  1                     with out_valid: last row of frame
// BEHAVIOUR
// Reset: all outputs 0; both banks EMPTY; wr_bank=rd_bank=0; counters 0; RD FSM=IDLE.
// Reset mid-operation discards partial and full frames; no output is completed.
// Bank state: per-bank flag full[1:0].
// Write: an accepted pop writes row wr_addr, then wr_addr++.
// Write: on the pop with wr_addr==WR_ROWS-1: next cycle full[wr_bank]=1, wr_bank toggles, wr_addr=0,
//   full_512=1 for exactly one cycle.
// wr_stall = full[wr_bank] (registered state). A pop while stalled: no write, no count; ovf_err<=1 until reset.
// RD FSM IDLE: if full[rd_bank] -> READ (next cycle), rd_addr=0.
// RD FSM READ: rd_en = out_ready. Each rd_en advances rd_addr. out_ready=0 pauses with no issue.
// RD FSM READ, row rd_addr==RD_ROWS-1 issued: full[rd_bank]<=0, rd_bank toggles, -> IDLE.
//   IDLE re-enters READ on the next cycle if the other bank is already full (1 idle bubble per frame).
// out_valid/out_sof/out_eof = rd_en, (rd_addr==0), (rd_addr==RD_ROWS-1), each piped RD_LAT cycles.
//   Downstream must sink data arriving RD_LAT cycles after issue, regardless of out_ready.
// Simultaneous set (write retire) and clear (read free) of full[] on different banks both take effect.
//   Same-bank set+clear cannot occur: a bank is written only while EMPTY.
// wr_stall drops the cycle after the freeing rd_en; writing resumes into the freed bank, wr_addr=0.
// Throughput: write 1 row/cycle, read 1 row/cycle. Read side needs 2x write rows per frame.
// TESTING
// 16 consecutive pops, out_ready=1 -> full_512 pulse at cycle 17, then 32 rd_en rows 0..31 on bank 0.
//   Also: out_sof on first out_valid, out_eof on 32nd.
// 32 pops back-to-back, out_ready=0 -> full_512 twice, wr_stall=1 after 2nd.
//   Then out_ready=1 -> bank0 read, 1 bubble, bank1 read.
// Both banks full + 3 extra pops -> no wr_en, ovf_err=1 sticky, wr_addr stays 0.
// out_ready toggled 1/0 every cycle during READ -> rd_addr advances only on ready cycles.
//   out_valid trails rd_en by RD_LAT.
// Last read row of bank0 in same cycle as 16th pop of bank1 -> full=2'b10 next cycle.
//   Also: wr_bank=0, no stall, no ovf.
// rstn low at pop 9 and again mid-READ row 12 -> all outputs 0.
//   Next 16 pops fill bank 0 from wr_addr 0.

Source files
------------

// File: rtl/fft_out_pingpong_ctrl.sv
// fft_out_pingpong_ctrl: ping-pong bank sequencing for the 512-point FFT output buffer
module fft_out_pingpong_ctrl #(
  parameter int N_POINT    = 512,
  parameter int WR_SAMPLES = 32,
  parameter int RD_SAMPLES = 16,
  parameter int RD_LAT     = 1,
  localparam int WR_ROWS   = N_POINT / WR_SAMPLES,
  localparam int RD_ROWS   = N_POINT / RD_SAMPLES,
  localparam int WAW       = $clog2(WR_ROWS),
  localparam int RAW       = $clog2(RD_ROWS)
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cbfp2_pop,
  output logic           wr_en,
  output logic           wr_bank,
  output logic [WAW-1:0] wr_addr,
  output logic           wr_stall,
  output logic           full_512,
  output logic           ovf_err,
  input  logic           out_ready,
  output logic           rd_en,
  output logic           rd_bank,
  output logic [RAW-1:0] rd_addr,
  output logic           out_valid,
  output logic           out_sof,
  output logic           out_eof
);
  typedef enum logic {IDLE, READ} rd_state_t;
  rd_state_t state, state_nx;
  logic [1:0] full;
  logic       wr_last, rd_last;
  logic [2:0] pipe [RD_LAT];
  assign wr_stall = full[wr_bank];
  assign wr_en    = cbfp2_pop & ~wr_stall;
  assign wr_last  = wr_en && wr_addr == WAW'(WR_ROWS - 1);
  assign rd_en    = (state == READ) & out_ready;
  assign rd_last  = rd_en && rd_addr == RAW'(RD_ROWS - 1);
  assign {out_valid, out_sof, out_eof} = pipe[RD_LAT-1];
  always_comb begin
    state_nx = (state == IDLE) ? (full[rd_bank] ? READ : IDLE) : (rd_last ? IDLE : READ);
  end
  // retire and free always hit different banks, so set and clear compose freely
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      full     <= '0;
      wr_bank  <= 1'b0;
      wr_addr  <= '0;
      full_512 <= 1'b0;
      ovf_err  <= 1'b0;
      rd_bank  <= 1'b0;
      rd_addr  <= '0;
    end else begin
      state    <= state_nx;
      full     <= (full | (2'(wr_last) << wr_bank)) & ~(2'(rd_last) << rd_bank);
      wr_bank  <= wr_bank ^ wr_last;
      wr_addr  <= wr_last ? '0 : wr_addr + WAW'(wr_en);
      full_512 <= wr_last;
      ovf_err  <= ovf_err | (cbfp2_pop & wr_stall);
      rd_bank  <= rd_bank ^ rd_last;
      rd_addr  <= rd_last ? '0 : rd_addr + RAW'(rd_en);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {rd_en, rd_en && rd_addr == '0, rd_last};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule
